// File: rtl/pea_host_sequencer_if.sv
// PEA-side bus of the host sequencer: input FIFO writes, invoke/enable/fc
// handshake, and result/status FIFO reads.
interface pea_host_sequencer_if #(
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 1024,
  parameter int OUT_DEPTH  = 32
);
  localparam int FSW  = $clog2(FIFO_DEPTH);
  localparam int POPW = $clog2(OUT_DEPTH);

  logic                 cmd_wr_en;
  logic [WIDTH-1:0]     cmd_data;
  logic [FSW-1:0]       cmd_free_space;
  logic                 data_wr_en;
  logic [WIDTH-1:0]     data_data;
  logic [FSW-1:0]       data_free_space;
  logic [1:0]           next_instr;
  logic                 invoke;
  logic                 enable;
  logic                 fc;
  logic                 result_rd_en;
  logic                 status_rd_en;
  logic [POPW-1:0]      result_pop;
  logic [POPW-1:0]      status_pop;
  logic [OUT_WIDTH-1:0] result_in;
  logic [OUT_WIDTH-1:0] status_in;

  modport master (
    output cmd_wr_en, cmd_data, data_wr_en, data_data, next_instr, invoke,
           result_rd_en, status_rd_en,
    input  cmd_free_space, data_free_space, enable, fc,
           result_pop, status_pop, result_in, status_in
  );

  modport slave (
    input  cmd_wr_en, cmd_data, data_wr_en, data_data, next_instr, invoke,
           result_rd_en, status_rd_en,
    output cmd_free_space, data_free_space, enable, fc,
           result_pop, status_pop, result_in, status_in
  );
endinterface

// File: rtl/pea_host_sequencer.sv
// Script-driven host sequencer for the PEA: executes a small on-chip program
// of FIFO pushes, mode selects, invoke/wait steps, drains and delays.
module pea_host_sequencer #(
  parameter int WIDTH        = 16,
  parameter int OUT_WIDTH    = 32,
  parameter int SCRIPT_DEPTH = 64,
  parameter int FIFO_DEPTH   = 1024,
  parameter int OUT_DEPTH    = 32,
  parameter int TIMEOUT      = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            script_wr_en,
  input  logic [$clog2(SCRIPT_DEPTH)-1:0] script_wr_addr,
  input  logic [WIDTH+3:0]                script_wr_data,
  pea_host_sequencer_if.master            pea,
  output logic                            cap_valid,
  output logic [OUT_WIDTH-1:0]            cap_result,
  output logic [OUT_WIDTH-1:0]            cap_status,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [2:0]                      error_code,
  output logic [$clog2(SCRIPT_DEPTH)-1:0] pc
);
  localparam int AW   = $clog2(SCRIPT_DEPTH);
  localparam int FSW  = $clog2(FIFO_DEPTH);
  localparam int POPW = $clog2(OUT_DEPTH);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_PUSH_CMD = 4'd1, OP_PUSH_DATA = 4'd2, OP_SET_MODE = 4'd3,
    OP_INVOKE_WAIT = 4'd4, OP_DRAIN = 4'd5, OP_DELAY = 4'd6, OP_HALT = 4'd7
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WAIT_EN, S_WAIT_FC,
    S_DRAIN_WAIT, S_DRAIN_RD, S_DRAIN_CAP, S_DELAY
  } state_t;

  state_t           state;
  logic [WIDTH+3:0] ram [SCRIPT_DEPTH];
  logic [WIDTH+3:0] instr;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] count;
  logic             step;

  assign opcode  = instr[WIDTH+3:WIDTH];
  assign operand = instr[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (script_wr_en && !busy) ram[script_wr_addr] <= script_wr_data;
    instr <= ram[pc];
  end

  // A step completes here; the FSM block applies the pc advance and overflow check.
  always_comb begin
    step = 1'b0;
    case (state)
      S_EXEC: begin
        case (opcode)
          OP_NOP, OP_SET_MODE: step = 1'b1;
          OP_PUSH_CMD:         step = (pea.cmd_free_space != FSW'(0));
          OP_PUSH_DATA:        step = (pea.data_free_space != FSW'(0));
          OP_DRAIN, OP_DELAY:  step = (operand == '0);
          default:             step = 1'b0;
        endcase
      end
      S_WAIT_FC:   step = pea.fc && !pea.invoke;
      S_DRAIN_CAP: step = (count == WIDTH'(1));
      S_DELAY:     step = (count == WIDTH'(1));
      default:     step = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pc               <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      error_code       <= '0;
      timer            <= '0;
      count            <= '0;
      pea.cmd_wr_en    <= 1'b0;
      pea.cmd_data     <= '0;
      pea.data_wr_en   <= 1'b0;
      pea.data_data    <= '0;
      pea.next_instr   <= 2'b00;
      pea.invoke       <= 1'b0;
      pea.result_rd_en <= 1'b0;
      pea.status_rd_en <= 1'b0;
      cap_valid        <= 1'b0;
      cap_result       <= '0;
      cap_status       <= '0;
    end else begin
      pea.cmd_wr_en    <= 1'b0;
      pea.data_wr_en   <= 1'b0;
      pea.invoke       <= 1'b0;
      pea.result_rd_en <= 1'b0;
      pea.status_rd_en <= 1'b0;
      cap_valid        <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          done       <= 1'b0;
          error      <= 1'b0;
          error_code <= '0;
          pc         <= '0;
          busy       <= 1'b1;
          state      <= S_FETCH;
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          case (opcode)
            OP_NOP: ;
            OP_PUSH_CMD: if (pea.cmd_free_space != FSW'(0)) begin
              pea.cmd_wr_en <= 1'b1;
              pea.cmd_data  <= operand;
            end
            OP_PUSH_DATA: if (pea.data_free_space != FSW'(0)) begin
              pea.data_wr_en <= 1'b1;
              pea.data_data  <= operand;
            end
            OP_SET_MODE: pea.next_instr <= operand[1:0];
            OP_INVOKE_WAIT: begin
              timer <= '0;
              state <= S_WAIT_EN;
            end
            OP_DRAIN: begin
              count <= operand;
              if (operand != '0) state <= S_DRAIN_WAIT;
            end
            OP_DELAY: begin
              count <= operand;
              if (operand != '0) state <= S_DELAY;
            end
            OP_HALT: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
            default: begin
              error      <= 1'b1;
              error_code <= 3'd1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end
          endcase
        end
        S_WAIT_EN: begin
          if (pea.enable) begin
            pea.invoke <= 1'b1;
            timer      <= '0;
            state      <= S_WAIT_FC;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            error      <= 1'b1;
            error_code <= 3'd4;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // The invoke cycle itself is the first cycle here, so fc is masked by invoke.
        S_WAIT_FC: if (!(pea.fc && !pea.invoke)) begin
          if (timer == TW'(TIMEOUT - 1)) begin
            error      <= 1'b1;
            error_code <= 3'd2;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DRAIN_WAIT:
          if (pea.result_pop != POPW'(0) && pea.status_pop != POPW'(0)) begin
            pea.result_rd_en <= 1'b1;
            pea.status_rd_en <= 1'b1;
            state            <= S_DRAIN_RD;
          end
        S_DRAIN_RD: state <= S_DRAIN_CAP;
        S_DRAIN_CAP: begin
          cap_result <= pea.result_in;
          cap_status <= pea.status_in;
          cap_valid  <= 1'b1;
          count      <= count - 1'b1;
          state      <= S_DRAIN_WAIT;
        end
        S_DELAY: count <= count - 1'b1;
        default: state <= S_IDLE;
      endcase

      if (step) begin
        if (pc == AW'(SCRIPT_DEPTH - 1)) begin
          error      <= 1'b1;
          error_code <= 3'd3;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end else begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_pea_host_sequencer.sv
// Scoreboard bench for pea_host_sequencer: a script-level reference model
// predicts FIFO writes, invokes, captures and the final status.
module tb_pea_host_sequencer;
  localparam int WIDTH = 16, OUT_WIDTH = 32, SCRIPT_DEPTH = 64;
  localparam int FIFO_DEPTH = 1024, OUT_DEPTH = 32, TIMEOUT = 16;
  localparam int AW = $clog2(SCRIPT_DEPTH), FSW = $clog2(FIFO_DEPTH), POPW = $clog2(OUT_DEPTH);

  logic clk = 1'b0;
  logic rst, start, script_wr_en;
  logic [AW-1:0] script_wr_addr;
  logic [WIDTH+3:0] script_wr_data;
  logic cap_valid, busy, done, error;
  logic [OUT_WIDTH-1:0] cap_result, cap_status;
  logic [2:0] error_code;
  logic [AW-1:0] pc;

  pea_host_sequencer_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH),
                          .FIFO_DEPTH(FIFO_DEPTH), .OUT_DEPTH(OUT_DEPTH)) bus ();

  pea_host_sequencer #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .SCRIPT_DEPTH(SCRIPT_DEPTH),
                       .FIFO_DEPTH(FIFO_DEPTH), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .script_wr_en(script_wr_en),
    .script_wr_addr(script_wr_addr), .script_wr_data(script_wr_data), .pea(bus),
    .cap_valid(cap_valid), .cap_result(cap_result), .cap_status(cap_status),
    .busy(busy), .done(done), .error(error), .error_code(error_code), .pc(pc)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [WIDTH+3:0] scr [SCRIPT_DEPTH];
  logic [WIDTH-1:0] exp_cmd[$], exp_data[$];
  logic [63:0] exp_cap[$];
  logic [31:0] env_res[$], env_sts[$], m_res[$], m_sts[$];
  int exp_inv, inv_seen = 0, inv_base, last_inv_cyc = 0, end_cyc;
  logic exp_done, exp_err;
  logic [2:0] exp_code;
  logic [AW-1:0] exp_pc;
  logic [1:0] m_mode;
  logic env_enable = 1'b1;
  int fc_delay = 5, fc_cnt = 0, mon_ns;
  bit rand_fs = 1'b0;
  logic [FSW-1:0] cfs_val = '1, dfs_val = '1, cfs_seen, dfs_seen;
  logic [POPW-1:0] rpop_seen, spop_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output FIFO model: one-cycle read latency, head appears after rd_en.
  always @(posedge clk) begin
    rpop_seen <= bus.result_pop;
    spop_seen <= bus.status_pop;
    cfs_seen  <= bus.cmd_free_space;
    dfs_seen  <= bus.data_free_space;
    if (bus.result_rd_en && env_res.size() > 0) bus.result_in <= env_res.pop_front();
    if (bus.status_rd_en && env_sts.size() > 0) bus.status_in <= env_sts.pop_front();
    bus.result_pop <= POPW'(env_res.size());
    bus.status_pop <= POPW'(env_sts.size());
  end

  always @(negedge clk) begin
    if (rand_fs) begin
      bus.cmd_free_space  = ($urandom % 3 == 0) ? '0 : FSW'($urandom_range(1, 1023));
      bus.data_free_space = ($urandom % 3 == 0) ? '0 : FSW'($urandom_range(1, 1023));
    end else begin
      bus.cmd_free_space  = cfs_val;
      bus.data_free_space = dfs_val;
    end
    bus.enable = env_enable;
    if (rst) begin
      fc_cnt = 0;
      bus.fc = 1'b0;
    end else if (bus.invoke) begin
      fc_cnt = fc_delay;
      bus.fc = 1'b0;
    end else if (fc_cnt > 0) begin
      fc_cnt--;
      bus.fc = (fc_cnt == 0);
    end else begin
      bus.fc = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT emits a strobe or capture.
  always @(negedge clk) if (!rst) begin
    mon_ns = int'(bus.cmd_wr_en) + int'(bus.data_wr_en) + int'(bus.invoke) + int'(bus.result_rd_en);
    if (mon_ns != 0 || bus.status_rd_en) chk("strobe_excl", 64'(mon_ns), 64'd1);
    if (bus.result_rd_en || bus.status_rd_en) begin
      chk("rd_pair", 64'(bus.result_rd_en), 64'(bus.status_rd_en));
      chk("rd_pop_nonzero", 64'(rpop_seen != 0 && spop_seen != 0), 64'd1);
    end
    if (bus.cmd_wr_en) begin
      chk("cmd_stall", 64'(cfs_seen != 0), 64'd1);
      chk("cmd_expected", 64'(exp_cmd.size() > 0), 64'd1);
      if (exp_cmd.size() > 0) chk("cmd_data", 64'(bus.cmd_data), 64'(exp_cmd.pop_front()));
    end
    if (bus.data_wr_en) begin
      chk("data_stall", 64'(dfs_seen != 0), 64'd1);
      chk("data_expected", 64'(exp_data.size() > 0), 64'd1);
      if (exp_data.size() > 0) chk("data_data", 64'(bus.data_data), 64'(exp_data.pop_front()));
    end
    if (bus.invoke) begin
      inv_seen++;
      last_inv_cyc = cyc;
    end
    if (cap_valid) begin
      chk("cap_expected", 64'(exp_cap.size() > 0), 64'd1);
      if (exp_cap.size() > 0) chk("cap_pair", {cap_result, cap_status}, exp_cap.pop_front());
    end
  end

  // Reference model: interprets the script at step level, no cycle timing.
  task automatic model_run();
    int p = 0;
    logic [3:0] op;
    logic [WIDTH-1:0] arg;
    exp_done = 0; exp_err = 0; exp_code = 0; exp_inv = 0;
    forever begin
      op = scr[p][WIDTH+3:WIDTH];
      arg = scr[p][WIDTH-1:0];
      if (op == 4'd7) begin exp_done = 1; break; end
      if (op > 4'd7) begin exp_err = 1; exp_code = 1; break; end
      if (op == 4'd1) exp_cmd.push_back(arg);
      if (op == 4'd2) exp_data.push_back(arg);
      if (op == 4'd3) m_mode = arg[1:0];
      if (op == 4'd4) begin
        if (!env_enable) begin exp_err = 1; exp_code = 4; break; end
        exp_inv++;
        if (fc_delay < 0) begin exp_err = 1; exp_code = 2; break; end
      end
      if (op == 4'd5)
        for (int k = 0; k < int'(arg); k++) exp_cap.push_back({m_res.pop_front(), m_sts.pop_front()});
      if (p == SCRIPT_DEPTH - 1) begin exp_err = 1; exp_code = 3; break; end
      p++;
    end
    exp_pc = AW'(p);
  endtask

  task automatic clear_all();
    exp_cmd.delete(); exp_data.delete(); exp_cap.delete();
    env_res.delete(); env_sts.delete(); m_res.delete(); m_sts.delete();
  endtask

  task automatic preload(input logic [31:0] r, input logic [31:0] s);
    env_res.push_back(r); env_sts.push_back(s);
    m_res.push_back(r); m_sts.push_back(s);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_strobes"}, 64'({bus.cmd_wr_en, bus.data_wr_en, bus.invoke,
                                bus.result_rd_en, bus.status_rd_en, cap_valid}), 64'd0);
  endtask

  task automatic load_and_start(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      script_wr_en = 1; script_wr_addr = AW'(i); script_wr_data = scr[i];
    end
    @(negedge clk);
    script_wr_en = 0;
    repeat (2) @(negedge clk);
    model_run();
    inv_base = inv_seen;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (!(done || error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    end_cyc = cyc;
    chk({tag, "_ended"}, 64'(done || error), 64'd1);
    if (done || error) begin
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
      chk({tag, "_error"}, 64'(error), 64'(exp_err));
      chk({tag, "_code"}, 64'(error_code), 64'(exp_code));
      chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_mode"}, 64'(bus.next_instr), 64'(m_mode));
      chk({tag, "_invokes"}, 64'(inv_seen - inv_base), 64'(exp_inv));
      chk({tag, "_pending"}, 64'(exp_cmd.size() + exp_data.size() + exp_cap.size()), 64'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int len, tot;
    logic [3:0] op;
    logic [WIDTH-1:0] arg;
    rst = 1; start = 0; script_wr_en = 0; script_wr_addr = '0; script_wr_data = '0;
    m_mode = 0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    chk("reset_done_err", 64'({done, error, error_code}), 64'd0);
    chk("reset_pc_mode", 64'({pc, bus.next_instr}), 64'd0);
    rst = 0;
    @(negedge clk);

    clear_all(); fc_delay = 10;
    scr[0] = {4'd3, 16'h0002}; scr[1] = {4'd1, 16'h1234}; scr[2] = {4'd1, 16'h0005};
    scr[3] = {4'd4, 16'h0000}; scr[4] = {4'd7, 16'h0000};
    load_and_start(5);
    finish_run("basic");

    clear_all(); dfs_val = '0;
    for (int i = 0; i < 6; i++) scr[i] = {4'd2, 16'($urandom)};
    scr[6] = {4'd7, 16'h0000};
    load_and_start(7);
    repeat (20) @(negedge clk);
    chk("stall_pending", 64'(exp_data.size()), 64'd6);
    dfs_val = '1;
    finish_run("stall");

    clear_all(); fc_delay = -1;
    scr[0] = {4'd4, 16'h0000}; scr[1] = {4'd7, 16'h0000};
    load_and_start(2);
    finish_run("fc_timeout");
    chk("fc_timeout_latency", 64'(end_cyc - last_inv_cyc <= TIMEOUT + 3), 64'd1);
    env_enable = 0; fc_delay = 3;
    load_and_start(2);
    finish_run("en_timeout");
    env_enable = 1;

    clear_all();
    preload(32'hA, 32'hB); preload(32'hC, 32'hD); preload(32'hE, 32'hF);
    scr[0] = {4'd5, 16'd3}; scr[1] = {4'd7, 16'h0000};
    load_and_start(2);
    finish_run("drain");
    chk("drain_fifo_empty", 64'(env_res.size() + env_sts.size()), 64'd0);

    clear_all();
    scr[0] = {4'd0, 16'h0}; scr[1] = {4'd0, 16'h0}; scr[2] = {4'hC, 16'h0};
    load_and_start(3);
    finish_run("illegal");
    for (int i = 0; i < SCRIPT_DEPTH; i++) scr[i] = {4'd0, 16'($urandom)};
    load_and_start(SCRIPT_DEPTH);
    finish_run("pc_overflow");

    clear_all(); fc_delay = -1;
    scr[0] = {4'd1, 16'h0077}; scr[1] = {4'd4, 16'h0000}; scr[2] = {4'd7, 16'h0000};
    load_and_start(3);
    for (int n = 0; n < 200 && inv_seen == inv_base; n++) @(negedge clk);
    chk("rst_reached_invoke", 64'(inv_seen - inv_base), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_quiet("mid_rst");
    chk("mid_rst_mode", 64'(bus.next_instr), 64'd0);
    rst = 0; m_mode = 0;
    clear_all(); fc_delay = 5;
    load_and_start(3);
    finish_run("rerun");

    rand_fs = 1;
    for (int it = 0; it < 30; it++) begin
      clear_all();
      len = $urandom_range(2, 14);
      tot = 0;
      fc_delay = $urandom_range(1, 8);
      for (int i = 0; i < len - 1; i++) begin
        op = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 6));
        arg = 16'($urandom);
        if (op == 4'd6) arg = 16'($urandom_range(0, 6));
        if (op == 4'd5) begin
          arg = 16'($urandom_range(0, 3));
          if (tot + int'(arg) > 30) arg = 0;
          tot += int'(arg);
        end
        scr[i] = {op, arg};
      end
      scr[len-1] = {4'd7, 16'h0000};
      for (int k = 0; k < tot; k++) preload($urandom, $urandom);
      load_and_start(len);
      finish_run("random");
    end
    rand_fs = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
